// File: rtl/regfile_pkg.sv
// Shared sizing defaults and types for the 2-read/1-write register file.
package regfile_pkg;

  localparam int DEFAULT_REG_LENGTH = 64;
  localparam int DEFAULT_NUM_REGS   = 32;
  localparam int DEFAULT_ZERO_REG   = 31;
  localparam int ADDR_W             = $clog2(DEFAULT_NUM_REGS);

  typedef logic [ADDR_W-1:0]             reg_addr_t;
  typedef logic [DEFAULT_REG_LENGTH-1:0] word_t;

endpackage

// File: rtl/reg_write_decoder.sv
// Write-address decoder: one-hot entry select gated by the write enable.
// The hardwired-zero entry and out-of-range addresses never get a select line.
module reg_write_decoder #(
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31,
  parameter int ADDR_W   = 5
) (
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_REGS-1:0] wr_sel
);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i)) && (i != ZERO_REG)) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// NUM_REGS x REG_LENGTH register file, one synchronous write port, two combinational reads.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto a matching read port.
module reg_file_2r1w
  import regfile_pkg::*;
#(
  parameter int REG_LENGTH = DEFAULT_REG_LENGTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int ZERO_REG   = DEFAULT_ZERO_REG,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [REG_LENGTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_a_addr_i,
  input  logic [AW-1:0]         rd_b_addr_i,
  output logic [REG_LENGTH-1:0] rd_a_data_o,
  output logic [REG_LENGTH-1:0] rd_b_data_o
);

  logic [NUM_REGS-1:0]                 wr_sel;
  logic [NUM_REGS-1:0][REG_LENGTH-1:0] regs;

  reg_write_decoder #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (AW)
  ) u_dec (
    .wr_en   (wr_en_i),
    .wr_addr (wr_addr_i),
    .wr_sel  (wr_sel)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    logic [REG_LENGTH-1:0] q;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        q <= '0;
      end else if (wr_sel[g]) begin
        q <= wr_data_i;
      end
    end

    assign regs[g] = q;
  end

  // Zero-force covers ZERO_REG and out-of-range addresses; forwarding is held off during reset.
  always_comb begin
    rd_a_data_o = '0;
    if ((32'(rd_a_addr_i) < NUM_REGS) && (32'(rd_a_addr_i) != ZERO_REG)) begin
      rd_a_data_o = regs[rd_a_addr_i];
`ifdef REGFILE_BYPASS_EN
      if (!reset_i && wr_en_i && (wr_addr_i == rd_a_addr_i)) begin
        rd_a_data_o = wr_data_i;
      end
`endif
    end
  end

  always_comb begin
    rd_b_data_o = '0;
    if ((32'(rd_b_addr_i) < NUM_REGS) && (32'(rd_b_addr_i) != ZERO_REG)) begin
      rd_b_data_o = regs[rd_b_addr_i];
`ifdef REGFILE_BYPASS_EN
      if (!reset_i && wr_en_i && (wr_addr_i == rd_b_addr_i)) begin
        rd_b_data_o = wr_data_i;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: array reference model plus directed literal checks.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_reg_file_2r1w;
  import regfile_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [4:0]  wr_addr_i = '0;
  logic [63:0] wr_data_i = '0;
  logic [4:0]  rd_a_addr_i = '0;
  logic [4:0]  rd_b_addr_i = '0;
  logic [63:0] rd_a_data_o;
  logic [63:0] rd_b_data_o;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  word_t mdl [32];

  reg_file_2r1w dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .rd_a_addr_i (rd_a_addr_i),
    .rd_b_addr_i (rd_b_addr_i),
    .rd_a_data_o (rd_a_data_o),
    .rd_b_data_o (rd_b_data_o)
  );

  always #5 clk_i = ~clk_i;

  initial for (int i = 0; i < 32; i++) mdl[i] = '0;

  // Reference model: storage is a plain array, entry 31 is never stored.
  always @(posedge reset_i) for (int i = 0; i < 32; i++) mdl[i] = '0;

  always @(posedge clk_i) begin
    if (!reset_i && wr_en_i && wr_addr_i != 5'd31) mdl[wr_addr_i] = wr_data_i;
  end

  function automatic logic [63:0] expect_rd(input logic [4:0] a);
    if (a == 5'd31) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!reset_i && wr_en_i && wr_addr_i == a) return wr_data_i;
`endif
    return mdl[a];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  always @(negedge clk_i) begin
    if (check_en) begin
      check("model_rd_a", rd_a_data_o, expect_rd(rd_a_addr_i));
      check("model_rd_b", rd_b_data_o, expect_rd(rd_b_addr_i));
    end
  end

  task automatic next_drive();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    logic [63:0] exp_pre;

    // Test 1: reset, then every address reads zero on both ports.
    repeat (2) @(posedge clk_i);
    #2 reset_i = 1'b0;
    check_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_a_addr_i = 5'(i);
      rd_b_addr_i = 5'(31 - i);
      #1;
      check("reset_rd_a", rd_a_data_o, 64'h0);
      check("reset_rd_b", rd_b_data_o, 64'h0);
    end

    // Test 2: write X5, both ports see it one edge later.
    next_drive();
    wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 64'hDEAD_BEEF_0123_4567;
    next_drive();
    wr_en_i = 1'b0; rd_a_addr_i = 5'd5; rd_b_addr_i = 5'd5;
    #1;
    check("x5_rd_a", rd_a_data_o, 64'hDEAD_BEEF_0123_4567);
    check("x5_rd_b", rd_b_data_o, 64'hDEAD_BEEF_0123_4567);

    // Test 3: write to the zero entry is dropped and disturbs nothing.
    next_drive();
    wr_en_i = 1'b1; wr_addr_i = 5'd31; wr_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_a_addr_i = 5'd31; rd_b_addr_i = 5'd31;
    #1;
    check("x31_pre_a", rd_a_data_o, 64'h0);
    next_drive();
    wr_en_i = 1'b0;
    #1;
    check("x31_rd_a", rd_a_data_o, 64'h0);
    check("x31_rd_b", rd_b_data_o, 64'h0);
    for (int i = 0; i < 32; i++) begin
      rd_a_addr_i = 5'(i);
      #1;
      check("x31_others", rd_a_data_o, (i == 5) ? 64'hDEAD_BEEF_0123_4567 : 64'h0);
    end

    // Test 4: same-cycle read/write of X7.
    next_drive();
    wr_en_i = 1'b1; wr_addr_i = 5'd7; wr_data_i = 64'h1234;
    rd_a_addr_i = 5'd7; rd_b_addr_i = 5'd6;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 64'h1234;
`else
    exp_pre = 64'h0;
`endif
    #1;
    check("x7_pre_edge", rd_a_data_o, exp_pre);
    check("x7_other_port", rd_b_data_o, 64'h0);
    next_drive();
    wr_en_i = 1'b0;
    #1;
    check("x7_post_edge", rd_a_data_o, 64'h1234);

    // Test 5: async reset clears mid-cycle; a write under reset is ignored.
    next_drive();
    wr_en_i = 1'b1; wr_addr_i = 5'd2; wr_data_i = 64'hAA;
    next_drive();
    wr_en_i = 1'b0; rd_a_addr_i = 5'd2; rd_b_addr_i = 5'd3;
    #1;
    check("x2_written", rd_a_data_o, 64'hAA);
    #1 reset_i = 1'b1;
    #1;
    check("x2_async_clr", rd_a_data_o, 64'h0);
    wr_en_i = 1'b1; wr_addr_i = 5'd3; wr_data_i = 64'h55;
    next_drive();
    check("x3_during_rst", rd_b_data_o, 64'h0);
    wr_en_i = 1'b0; reset_i = 1'b0;
    #1;
    check("x3_after_rst", rd_b_data_o, 64'h0);
    check("x2_after_rst", rd_a_data_o, 64'h0);

    // Test 6: back-to-back fill of X0..X30, paired readback.
    for (int i = 0; i < 31; i++) begin
      next_drive();
      wr_en_i = 1'b1; wr_addr_i = 5'(i); wr_data_i = 64'(i) * 64'h0101;
    end
    next_drive();
    wr_en_i = 1'b0;
    for (int i = 0; i < 31; i++) begin
      rd_a_addr_i = 5'(i);
      rd_b_addr_i = 5'(30 - i);
      #1;
      check("fill_rd_a", rd_a_data_o, 64'(i) * 64'h0101);
      check("fill_rd_b", rd_b_data_o, 64'(30 - i) * 64'h0101);
    end
    rd_a_addr_i = 5'd31;
    #1;
    check("fill_x31", rd_a_data_o, 64'h0);

    // Random traffic against the model, with occasional mid-cycle reset pulses.
    for (int n = 0; n < 400; n++) begin
      next_drive();
      wr_en_i   = ($urandom_range(0, 3) != 0);
      wr_addr_i = 5'($urandom_range(0, 31));
      wr_data_i = {$urandom, $urandom};
      rd_a_addr_i = ($urandom_range(0, 3) == 0) ? wr_addr_i : 5'($urandom_range(0, 31));
      rd_b_addr_i = ($urandom_range(0, 3) == 0) ? wr_addr_i : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 60) == 0) begin
        #1 reset_i = 1'b1;
        #1 reset_i = 1'b0;
      end
    end

    next_drive();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
